seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment driver for the note display. Takes a binary value (MIDI note number by default) with a load strobe, converts it to BCD with a sequential double-dabble engine, and time-multiplexes DIGITS digits onto one shared segment bus with a one-hot digit select. Supersedes the fixed two-digit combinational decoder. Adds arbitrary width and digit count, leading-zero blanking, overflow indication, decimal points and scanning.

---
 rtl/seg_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg_scan_driver.sv | 113 +++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-dabble BCD converter feeding a scanned multi-digit seven-segment display
module seg_scan_driver #(
  parameter int DIGITS     = 2,
  parameter int VALUE_W    = 8,
  parameter int SCAN_DIV   = 50000,
  parameter bit LEAD_BLANK = 1'b1,
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic [DIGITS-1:0]  dp_mask,
  output logic               busy,
  output logic [7:0]         seg,
  output logic [DIGITS-1:0]  dig_sel
);
  localparam int BW = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = VALUE_W > 1 ? $clog2(VALUE_W) : 1;
  localparam longint unsigned LIMIT = 10 ** DIGITS;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  state_t state, state_n;
  logic [VALUE_W-1:0] sh, pend_val, src;
  logic [BW-1:0] bcd, bcd_adj, disp_bcd;
  logic [CW-1:0] cnt;
  logic pend, start, conv_ovf, conv_zero, disp_ovf, disp_zero;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx, idx_n;
  logic wrap, up_zero;
  logic [3:0] nib;
  logic [6:0] dig_g;
  logic [7:0] seg_n;
  always_comb begin
    state_n = state;
    start = 1'b0;
    src = value;
    case (state)
      IDLE: begin
        start = load;
        state_n = load ? CONV : IDLE;
      end
      CONV: state_n = cnt == CW'(VALUE_W - 1) ? COMMIT : CONV;
      COMMIT: begin
        start = load | pend;
        src = load ? value : pend_val;
        state_n = (load | pend) ? CONV : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign bcd_adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pend <= 1'b0;
      pend_val <= '0;
      cnt <= '0;
      sh <= '0;
      bcd <= '0;
      conv_ovf <= 1'b0;
      conv_zero <= 1'b1;
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
      disp_zero <= 1'b1;
    end else begin
      state <= state_n;
      if (start) begin
        sh <= src;
        bcd <= '0;
        cnt <= '0;
        conv_ovf <= 64'(src) >= LIMIT;
        conv_zero <= src == '0;
      end else if (state == CONV) begin
        sh <= sh << 1;
        bcd <= {bcd_adj[BW-2:0], sh[VALUE_W-1]};
        cnt <= cnt + 1'b1;
      end
      if (state == COMMIT) begin
        disp_bcd <= bcd;
        disp_ovf <= conv_ovf;
        disp_zero <= conv_zero;
        pend <= 1'b0;
      end else if (busy && load) begin
        pend <= 1'b1;
        pend_val <= value;
      end
    end
  end
  assign wrap = presc == PW'(SCAN_DIV - 1);
  assign idx_n = wrap ? (idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1) : idx;
  always_comb begin
    nib = disp_bcd[4*idx_n+:4];
    up_zero = (disp_bcd >> (4 * idx_n)) == '0;
    case (nib)
      4'd0: dig_g = 7'h3f;
      4'd1: dig_g = 7'h06;
      4'd2: dig_g = 7'h5b;
      4'd3: dig_g = 7'h4f;
      4'd4: dig_g = 7'h66;
      4'd5: dig_g = 7'h6d;
      4'd6: dig_g = 7'h7d;
      4'd7: dig_g = 7'h07;
      4'd8: dig_g = 7'h7f;
      4'd9: dig_g = 7'h6f;
      default: dig_g = 7'h00;
    endcase
    seg_n[6:0] = disp_ovf ? 7'h40 :
                 (disp_zero && BLANK_ZERO) ? 7'h00 :
                 (LEAD_BLANK && idx_n != '0 && up_zero) ? 7'h00 : dig_g;
    seg_n[7] = dp_mask[idx_n];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx <= '0;
      dig_sel <= DIGITS'(1);
      seg <= 8'h00;
    end else begin
      presc <= wrap ? '0 : presc + 1'b1;
      idx <= idx_n;
      dig_sel <= DIGITS'(1) << idx_n;
      seg <= seg_n;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: two parameterisations driven together, checked against an arithmetic display model
module tb_seg_scan_driver;
  localparam int VW = 8, D1 = 2, S1 = 4, D2 = 3, S2 = 3;
  localparam logic [7:0] GLYPH [10] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07, 8'h7f, 8'h6f};
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [VW-1:0] value = '0;
  logic [D1-1:0] dpa = '0;
  logic [D2-1:0] dpb = '0;
  logic busy_a, busy_b;
  logic [7:0] seg_a, seg_b;
  logic [D1-1:0] sel_a;
  logic [D2-1:0] sel_b;
  int checks = 0, errors = 0;
  int k = 0, disp = 0, cur = 0, left = 0, pv = 0;
  bit pend = 1'b0;
  int edges [8] = '{0, 9, 10, 99, 100, 101, 127, 255};
  always #5 clk = ~clk;
  seg_scan_driver #(.DIGITS(D1), .VALUE_W(VW), .SCAN_DIV(S1), .LEAD_BLANK(1'b1), .BLANK_ZERO(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_mask(dpa),
    .busy(busy_a), .seg(seg_a), .dig_sel(sel_a));
  seg_scan_driver #(.DIGITS(D2), .VALUE_W(VW), .SCAN_DIV(S2), .LEAD_BLANK(1'b0), .BLANK_ZERO(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_mask(dpb),
    .busy(busy_b), .seg(seg_b), .dig_sel(sel_b));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask
  function automatic logic [7:0] glyph(input int v, input int i, input int d, input bit lb, input bit bz, input bit dp);
    int p, lim;
    logic [7:0] g;
    p = 1;
    lim = 1;
    for (int j = 0; j < i; j++) p *= 10;
    for (int j = 0; j < d; j++) lim *= 10;
    if (v >= lim) g = 8'h40;
    else if (v == 0 && bz) g = 8'h00;
    else if (lb && i > 0 && v < p) g = 8'h00;
    else g = GLYPH[(v / p) % 10];
    return {dp, g[6:0]};
  endfunction
  task automatic step(input bit r, input bit ld, input int v);
    int ia, ib;
    logic [7:0] ea, eb;
    rst_n = r;
    load = ld;
    value = VW'(v);
    dpa = D1'($urandom);
    dpb = D2'($urandom);
    @(posedge clk);
    if (!r) begin
      k = 0; disp = 0; left = 0; pend = 1'b0;
      ia = 0; ib = 0; ea = 8'h00; eb = 8'h00;
    end else begin
      k++;
      ia = (k / S1) % D1;
      ib = (k / S2) % D2;
      ea = glyph(disp, ia, D1, 1'b1, 1'b1, dpa[ia]);
      eb = glyph(disp, ib, D2, 1'b0, 1'b0, dpb[ib]);
      if (left > 0) begin
        if (ld) begin pend = 1'b1; pv = v; end
        left--;
        if (left == 0) begin
          disp = cur;
          if (pend) begin cur = pv; pend = 1'b0; left = VW + 1; end
        end
      end else if (ld) begin
        cur = v;
        left = VW + 1;
      end
    end
    @(negedge clk);
    check("seg_a", 32'(seg_a), 32'(ea));
    check("sel_a", 32'(sel_a), 32'(1) << ia);
    check("busy_a", 32'(busy_a), 32'(left > 0));
    check("seg_b", 32'(seg_b), 32'(eb));
    check("sel_b", 32'(sel_b), 32'(1) << ib);
    check("busy_b", 32'(busy_b), 32'(left > 0));
  endtask
  initial begin
    repeat (2) step(1'b0, 1'b0, 0);
    foreach (edges[n]) begin
      step(1'b1, 1'b1, edges[n]);
      repeat (20) step(1'b1, 1'b0, 0);
    end
    step(1'b1, 1'b1, 60);
    repeat (20) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 5);
    repeat (20) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 42);
    repeat (3) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 99);
    repeat (3) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 17);
    repeat (30) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 50);
    repeat (8) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 77);
    repeat (30) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 88);
    repeat (4) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 33);
    repeat (20) step(1'b1, 1'b0, 0);
    for (int c = 0; c < 4000; c++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0 ? edges[$urandom_range(0, 7)] : int'($urandom_range(0, 255)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
